// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and default widths shared by the ALU arbiter slice.
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int SEL_W_DEF  = 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NEG  = 3'b101;
   localparam logic [2:0] OP_RSV0 = 3'b110;
   localparam logic [2:0] OP_RSV1 = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arb2.sv
// Two-input round-robin grant: zero latency, combinational one-hot grant.
// A lone requester always wins; on a tie the one that did not win last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   assign grant[0] = req[0] & (~req[1] | last_grant);
   assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational ALU between two requesters; accept at N -> rsp_valid at N+2, 3 cycles min per op.
// Response held stable under rsp_ready backpressure; no new accept until it drains. Option: ALU_ARB_ZERO_FLAG_EN adds rsp_zero.
module alu_arbiter_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   input  logic [2*SEL_W-1:0]  req_sel,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [SEL_W-1:0]    alu_sel,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic                alu_carry,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_carry,
`ifdef ALU_ARB_ZERO_FLAG_EN
   output logic                rsp_zero,
`endif
   output logic                rsp_err,
   output logic                busy
);

   localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(OP_ADD);
   localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(OP_SUB);
   localparam logic [SEL_W-1:0] SEL_RSV0 = SEL_W'(OP_RSV0);
   localparam logic [SEL_W-1:0] SEL_RSV1 = SEL_W'(OP_RSV1);

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
   logic                rsp_valid_q, rsp_valid_d, busy_q, busy_d;
   logic                rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic [1:0]          grant;
   logic                g;
   logic                op_err;

   rr_arb2 u_rr_arb2 (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign g      = grant[1];
   assign op_err = (alu_sel_q == SEL_RSV0) || (alu_sel_q == SEL_RSV1);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;
      rsp_zero_d   = rsp_zero_q;
      req_ready    = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready    = grant;
               alu_a_d      = g ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
               alu_b_d      = g ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
               alu_sel_d    = g ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
               rsp_id_d     = g;
               last_grant_d = g;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Carry is only meaningful for add/sub; reserved opcodes force a zero result.
            rsp_data_d  = op_err ? '0 : alu_out;
            rsp_carry_d = ((alu_sel_q == SEL_ADD) || (alu_sel_q == SEL_SUB)) ? alu_carry : 1'b0;
            rsp_err_d   = op_err;
            rsp_zero_d  = (alu_out == '0) && !op_err;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_err_q    <= rsp_err_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_err   = rsp_err_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
   assign rsp_zero  = rsp_zero_q;
`else
   logic unused_zero;
   assign unused_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_arbiter_ctrl;

   logic        clk, rst;
   logic [1:0]  req_valid, req_ready;
   logic [15:0] req_a, req_b;
   logic [5:0]  req_sel;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [2:0]  alu_sel;
   logic        alu_carry;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
   logic [7:0]  rsp_data;
`ifdef ALU_ARB_ZERO_FLAG_EN
   logic        rsp_zero;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   alu_arbiter_ctrl #(.DATA_W(8), .SEL_W(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry),
`ifdef ALU_ARB_ZERO_FLAG_EN
      .rsp_zero(rsp_zero),
`endif
      .rsp_err(rsp_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: carry is deliberately junk on non-arithmetic ops and result junk on reserved ops.
   always_comb begin
      alu_out   = 8'h00;
      alu_carry = 1'b0;
      case (alu_sel)
         3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
         3'b010: begin alu_out = alu_a & alu_b; alu_carry = 1'b1; end
         3'b011: begin alu_out = alu_a | alu_b; alu_carry = 1'b1; end
         3'b100: begin alu_out = alu_a ^ alu_b; alu_carry = 1'b1; end
         3'b101: begin alu_out = 8'h00 - alu_a; alu_carry = 1'b1; end
         default: begin alu_out = 8'hA5; alu_carry = 1'b1; end
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      req_a[id*8 +: 8]   = a;
      req_b[id*8 +: 8]   = b;
      req_sel[id*3 +: 3] = s;
      req_valid[id]      = 1'b1;
   endtask

   // Called at a negedge in IDLE with request(s) already presented; returns at a negedge in IDLE.
   task automatic serve(input int id, input logic [7:0] d, input logic c, input logic e);
      logic [1:0] oh;
      oh = (id == 1) ? 2'b10 : 2'b01;
      #1;
      check("grant", {30'd0, req_ready}, {30'd0, oh});
      check("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      check("exec_busy", {31'd0, busy}, 32'd1);
      check("exec_vld", {31'd0, rsp_valid}, 32'd0);
      check("exec_rdy", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("rsp_vld", {31'd0, rsp_valid}, 32'd1);
      check("rsp_id", {31'd0, rsp_id}, id);
      check("rsp_data", {24'd0, rsp_data}, {24'd0, d});
      check("rsp_carry", {31'd0, rsp_carry}, {31'd0, c});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e});
`ifdef ALU_ARB_ZERO_FLAG_EN
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, (d == 8'h00) && !e});
`endif
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("drain_vld", {31'd0, rsp_valid}, 32'd0);
      check("drain_busy", {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      int         id;
      logic [7:0] a, b;
      logic [2:0] sel;
      logic [7:0] data;
      logic       carry, err;
   } vec_t;

   vec_t vecs[10];
   logic [7:0] held;

   initial begin
      vecs[0] = '{0, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0};
      vecs[1] = '{1, 8'h12, 8'h34, 3'b110, 8'h00, 1'b0, 1'b1};
      vecs[2] = '{0, 8'h01, 8'h00, 3'b101, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{1, 8'h3C, 8'hC3, 3'b011, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{0, 8'hAA, 8'h0F, 3'b100, 8'hA5, 1'b0, 1'b0};
      vecs[5] = '{1, 8'h80, 8'h7F, 3'b000, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{0, 8'h10, 8'h10, 3'b001, 8'h00, 1'b0, 1'b0};
      vecs[7] = '{1, 8'h00, 8'h00, 3'b111, 8'h00, 1'b0, 1'b1};
      vecs[8] = '{0, 8'h5A, 8'h5A, 3'b100, 8'h00, 1'b0, 1'b0};
      vecs[9] = '{1, 8'h01, 8'h01, 3'b000, 8'h02, 1'b0, 1'b0};

      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      req_a = 16'h0; req_b = 16'h0; req_sel = 6'h0;
      @(negedge clk);
      check("rst_vld", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu", {13'd0, alu_a, alu_b, alu_sel}, 32'd0);
      check("rst_rsp", {22'd0, rsp_id, rsp_data, rsp_err}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);

      // Single-requester table; the idle slot carries junk to catch mux errors.
      for (int i = 0; i < 10; i++) begin
         set_req(1 - vecs[i].id, 8'h77, 8'h99, 3'b010);
         req_valid[1 - vecs[i].id] = 1'b0;
         set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel);
         serve(vecs[i].id, vecs[i].data, vecs[i].carry, vecs[i].err);
      end

      // Round-robin on contention: last grant was 1, so order is 0,1,0,1.
      set_req(0, 8'h05, 8'h07, 3'b001);
      set_req(1, 8'hCC, 8'h0F, 3'b010);
      serve(0, 8'hFE, 1'b1, 1'b0);
      set_req(0, 8'h05, 8'h07, 3'b001);
      serve(1, 8'h0C, 1'b0, 1'b0);
      set_req(1, 8'hCC, 8'h0F, 3'b010);
      serve(0, 8'hFE, 1'b1, 1'b0);
      serve(1, 8'h0C, 1'b0, 1'b0);

      // Backpressure: response held for 5 cycles while requester 0 waits.
      set_req(1, 8'h40, 8'h30, 3'b000);
      #1 check("bp_grant", {30'd0, req_ready}, 32'd2);
      @(posedge clk); #1 req_valid[1] = 1'b0;
      set_req(0, 8'h09, 8'h03, 3'b001);
      @(negedge clk); @(negedge clk);
      held = rsp_data;
      check("bp_data0", {24'd0, held}, 32'h70);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_vld", {31'd0, rsp_valid}, 32'd1);
         check("bp_hold", {23'd0, rsp_id, rsp_data}, {23'd0, 1'b1, held});
         check("bp_rdy", {30'd0, req_ready}, 32'd0);
         check("bp_busy", {31'd0, busy}, 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      serve(0, 8'h06, 1'b0, 1'b0);

      // Reset during EXEC: last grant becomes 0 before reset, reset must restore priority to 0.
      set_req(0, 8'h11, 8'h22, 3'b000);
      #1 check("pre_rst_grant", {30'd0, req_ready}, 32'd1);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_alu", {13'd0, alu_a, alu_b, alu_sel}, 32'd0);
      check("arst_rsp", {21'd0, rsp_valid, rsp_id, rsp_data, rsp_err}, 32'd0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_vld", {31'd0, rsp_valid}, 32'd0);
      end
      set_req(0, 8'h02, 8'h03, 3'b000);
      set_req(1, 8'hFF, 8'hFF, 3'b011);
      serve(0, 8'h05, 1'b0, 1'b0);
      serve(1, 8'hFF, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Shares one combinational 8-bit ALU between two requesters, e.g. a switch/button front-end and a UART command decoder on the Basys3 board.
- Round-robin arbitration of two valid/ready request channels.
- Registers the operands and opcode and drives the ALU.
- Captures result and carry, returns them on a single tagged response channel with backpressure.
- Masks undefined carry for non-arithmetic ops and flags unsupported opcodes.

Parameters:
DATA_W, 8, operand/result width; must match the ALU instance.
SEL_W, 3, opcode width.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
req_valid  in  2  per-requester request valid; bit i = requester i.
req_ready  out  2  per-requester accept; one-hot or zero.
req_a  in  2*DATA_W  operand A; requester i at [i*DATA_W +: DATA_W].
req_b  in  2*DATA_W  operand B, same packing.
req_sel  in  2*SEL_W  opcode, same packing.
alu_a  out  DATA_W  to ALU A.
alu_b  out  DATA_W  to ALU B.
alu_sel  out  SEL_W  to ALU select.
alu_out  in  DATA_W  ALU result.
alu_carry  in  1  ALU carry out.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_id  out  1  requester index owning the response.
rsp_data  out  DATA_W  result.
rsp_carry  out  1  carry/borrow; 0 for non-arithmetic ops.
rsp_err  out  1  unsupported opcode (110, 111).
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_grant=1 so requester 0 wins first.
- Reset mid-operation: in-flight op and pending response are discarded; requesters must re-present.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, select grant g by round-robin: the requester other than last_grant wins when both are valid.
  - Assert req_ready[g] combinationally this cycle.
  - Latch the request's a/b/sel into alu_a/alu_b/alu_sel registers; set rsp_id=g and last_grant=g; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (one cycle): ALU settles from registered inputs. At the clock edge:
  - rsp_data <= alu_out.
  - rsp_carry <= alu_carry only when sel is 000 (add, 9-bit sum carry) or 001 (sub, 1 = borrow, A<B); otherwise 0.
  - rsp_err <= (sel == 110 or 111).
  - On error, rsp_data <= 0 regardless of alu_out.
  - Go to RESP.
- Opcode 101 yields two's-complement -A; rsp_carry=0.
- RESP:
  - rsp_valid=1; rsp_id/data/carry/err held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
- Latency: accept at cycle N gives rsp_valid at N+2. Minimum 3 cycles per op; no new accept in EXEC or RESP (req_ready=0).
- Requesters must hold req_valid and payload stable until req_ready. Deasserting without acceptance is permitted and simply drops out of arbitration.
- alu_a/alu_b/alu_sel hold their last values in IDLE and RESP.

Optional Feature:
Macro ALU_ARB_ZERO_FLAG_EN.
- Defined: extra output port rsp_zero (1 bit), registered in EXEC as (alu_out == 0) && !err. Reset value 0. Held with the rest of the response.
- Undefined: port and logic absent; interface otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NEG=101.
  - FSM state encoding (IDLE/EXEC/RESP).
  - DATA_W/SEL_W defaults.
- One natural sub-module: rr_arb2, the two-input round-robin grant logic (req[1:0], last_grant -> grant one-hot).
- FSM, operand registers and response registers stay in alu_arbiter_ctrl.

Test Plan:
- Reset; req0 valid a=0xF0 b=0x20 sel=000 -> req_ready[0] same cycle; 2 cycles later rsp_valid, id=0, data=0x10, carry=1, err=0.
- Both valid from IDLE after reset: req0 sub 0x05-0x07, req1 and 0xCC&0x0F.
  - First response: id=0, data=0xFE, carry=1.
  - Second response: id=1, data=0x0C, carry=0.
  - Repeat: grant order alternates 1,0.
- req1 sel=110 a=0x12 -> rsp data=0x00, err=1, carry=0. Also sel=101 a=0x01 -> data=0xFF, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready stays 0, busy=1. Release -> IDLE, next request accepted.
- Assert rst during EXEC -> all outputs 0 asynchronously, no response issued. After release, requester 0 wins a simultaneous request.
- With ALU_ARB_ZERO_FLAG_EN: xor 0x5A^0x5A -> rsp_zero=1, data=0x00. Add 0x01+0x01 -> rsp_zero=0.
